// File: rtl/bird_physics_if.sv
// Signal bundle between the bird physics stage and its neighbours:
// raw button, frame timing and collision in; bird position/state out.
interface bird_physics_if;
   logic       flap_btn;
   logic       vsync;
   logic       hit;
   logic [9:0] bird_y;
   logic [5:0] bird_vel;
   logic [1:0] game_state;
   logic       frame_tick;

   modport master (
      output flap_btn, vsync, hit,
      input  bird_y, bird_vel, game_state, frame_tick
   );

   modport slave (
      input  flap_btn, vsync, hit,
      output bird_y, bird_vel, game_state, frame_tick
   );
endinterface

// File: rtl/bird_physics.sv
// Flappy-bird vertical physics: debounced flap button, once-per-frame gravity
// and impulse integration, and the IDLE/PLAY/DEAD game state machine.
module bird_physics #(
   parameter int SCREEN_H        = 480,
   parameter int BIRD_SIZE       = 20,
   parameter int START_Y         = 240,
   parameter int GRAVITY         = 1,
   parameter int FLAP_IMPULSE    = 8,
   parameter int MAX_FALL        = 10,
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic          dclk,
   input  logic          clr,
   bird_physics_if.slave bus
);
   localparam int FLOOR_Y = SCREEN_H - BIRD_SIZE;
   localparam int CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic signed [10:0] GRAV_S  = 11'(GRAVITY);
   localparam logic signed [10:0] FALL_S  = 11'(MAX_FALL);
   localparam logic signed [10:0] IMP_S   = 11'(FLAP_IMPULSE);
   localparam logic signed [10:0] FLOOR_S = 11'(FLOOR_Y);
   localparam logic signed [10:0] ZERO_S  = 11'sd0;
   localparam logic signed [5:0]  VEL_UP  = -6'(FLAP_IMPULSE);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      PLAY = 2'b01,
      DEAD = 2'b10
   } state_t;

   logic             btn_meta;
   logic             btn_sync;
   logic             btn_prev;
   logic             btn_db;
   logic [CNT_W-1:0] db_cnt;
   logic             flap_req;
   logic             hit_latch;
   logic             vsync_q;
   logic             tick;

   state_t           state;
   logic [9:0]       y;
   logic signed [5:0] vel;

   logic             btn_stable;
   logic             flap_rise;
   logic signed [10:0] vel_ext;
   logic signed [10:0] v_grav;
   logic signed [10:0] v_new;
   logic signed [10:0] y_new;

   assign btn_stable = (btn_sync == btn_prev);
   // A flap is the debounced level being accepted high while it was low.
   assign flap_rise  = btn_stable && (db_cnt == CNT_LAST) && btn_sync && !btn_db;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge dclk or posedge clr) begin
      if (clr) begin
         btn_meta  <= 1'b0;
         btn_sync  <= 1'b0;
         btn_prev  <= 1'b0;
         btn_db    <= 1'b0;
         db_cnt    <= '0;
         flap_req  <= 1'b0;
         hit_latch <= 1'b0;
         vsync_q   <= 1'b0;
         tick      <= 1'b0;
      end else begin
         btn_meta <= bus.flap_btn;
         btn_sync <= btn_meta;
         btn_prev <= btn_sync;

         if (!btn_stable)
            db_cnt <= '0;
         else if (db_cnt == CNT_LAST)
            btn_db <= btn_sync;
         else
            db_cnt <= db_cnt + 1'b1;

         // Set wins over the frame-tick clear so late events roll into the next frame.
         if (flap_rise)
            flap_req <= 1'b1;
         else if (tick)
            flap_req <= 1'b0;

         if (bus.hit)
            hit_latch <= 1'b1;
         else if (tick)
            hit_latch <= 1'b0;

         vsync_q <= bus.vsync;
         tick    <= vsync_q & ~bus.vsync;
      end
   end

   // NOTE: every variable gets a value on every path through always_comb,
   // otherwise synthesis infers a latch.
   always_comb begin
      vel_ext = {{5{vel[5]}}, vel};
      v_grav  = vel_ext + GRAV_S;
      if (v_grav > FALL_S)
         v_grav = FALL_S;
      v_new = flap_req ? -IMP_S : v_grav;
      y_new = $signed({1'b0, y}) + v_new;
   end

   always_ff @(posedge dclk or posedge clr) begin
      if (clr) begin
         state <= IDLE;
         y     <= 10'(START_Y);
         vel   <= '0;
      end else if (tick) begin
         case (state)
            IDLE: begin
               if (flap_req) begin
                  state <= PLAY;
                  vel   <= VEL_UP;
               end
            end
            PLAY: begin
               if (y_new < ZERO_S) begin
                  y   <= '0;
                  vel <= '0;
               end else if (y_new >= FLOOR_S) begin
                  y     <= 10'(FLOOR_Y);
                  vel   <= '0;
                  state <= DEAD;
               end else begin
                  y   <= y_new[9:0];
                  vel <= v_new[5:0];
               end
               if (hit_latch)
                  state <= DEAD;
            end
            DEAD: begin
               if (flap_req) begin
                  state <= IDLE;
                  y     <= 10'(START_Y);
                  vel   <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.bird_y     = y;
   assign bus.bird_vel   = vel;
   assign bus.game_state = state;
   assign bus.frame_tick = tick;
endmodule

// File: tb/tb_bird_physics.sv
// Bench for bird_physics: frame-level reference model, per-cycle output
// comparison, directed scenarios with literal expectations, then random frames.
module tb_bird_physics;
   localparam int N_DB      = 4;
   localparam int FRAME_CYC = 40;

   logic dclk = 1'b0;
   logic clr;

   bird_physics_if bus ();

   bird_physics #(.DEBOUNCE_CYCLES(N_DB)) dut (
      .dclk (dclk),
      .clr  (clr),
      .bus  (bus)
   );

   always #20 dclk = ~dclk;

   int total = 0;
   int bad   = 0;
   int tick_seen = 0;
   int frames_run = 0;

   // Reference model state, advanced once per frame tick.
   int m_y, m_vel, m_state;
   bit pend_flap, pend_hit, exp_tick, chk_en;

   task automatic check(input string name, input logic signed [31:0] act,
                        input logic signed [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_y = 240; m_vel = 0; m_state = 0;
      pend_flap = 0; pend_hit = 0; exp_tick = 0;
   endtask

   task automatic model_tick();
      int v, yn;
      case (m_state)
         0: if (pend_flap) begin m_state = 1; m_vel = -8; end
         1: begin
            v  = pend_flap ? -8 : ((m_vel + 1 > 10) ? 10 : m_vel + 1);
            yn = m_y + v;
            if (yn < 0) begin m_y = 0; m_vel = 0; end
            else if (yn >= 460) begin m_y = 460; m_vel = 0; m_state = 2; end
            else begin m_y = yn; m_vel = v; end
            if (pend_hit) m_state = 2;
         end
         default: if (pend_flap) begin m_state = 0; m_y = 240; m_vel = 0; end
      endcase
      pend_flap = 0;
      pend_hit  = 0;
   endtask

   always @(negedge dclk) begin
      if (chk_en) begin
         check("bird_y", bus.bird_y, m_y);
         check("bird_vel", $signed(bus.bird_vel), m_vel);
         check("game_state", bus.game_state, m_state);
         check("frame_tick", bus.frame_tick, exp_tick);
         if (bus.frame_tick) tick_seen++;
      end
   end

   // mode: 0 idle, 1 press, 2 short glitch of glen cycles, 3 two presses
   task automatic run_frame(input int mode, input int glen, input bit hit_mid,
                            input bit hit_at_tick);
      for (int c = 0; c < FRAME_CYC; c++) begin
         @(negedge dclk);
         bus.flap_btn = ((mode == 1 || mode == 3) && c >= 5 && c < 13) ||
                        (mode == 2 && c >= 5 && c < 5 + glen) ||
                        (mode == 3 && c >= 22 && c < 30);
         bus.hit = hit_mid && (c == 18);
      end
      if (mode == 1 || mode == 3) pend_flap = 1;
      if (hit_mid) pend_hit = 1;
      @(negedge dclk);
      bus.vsync = 1'b0; bus.flap_btn = 1'b0; bus.hit = 1'b0;
      @(posedge dclk);
      exp_tick = 1;
      @(negedge dclk);
      bus.hit = hit_at_tick;
      @(posedge dclk);
      model_tick();
      exp_tick = 0;
      if (hit_at_tick) pend_hit = 1;
      @(negedge dclk);
      bus.hit = 1'b0;
      repeat (2) @(negedge dclk);
      bus.vsync = 1'b1;
      frames_run++;
   endtask

   task automatic pin(input string tag, input int ey, input int ev, input int es);
      check({tag, "_y"}, bus.bird_y, ey);
      check({tag, "_vel"}, $signed(bus.bird_vel), ev);
      check({tag, "_state"}, bus.game_state, es);
   endtask

   initial begin
      #(40 * 60000);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, guard;
      clr = 1'b1;
      bus.flap_btn = 1'b0; bus.vsync = 1'b1; bus.hit = 1'b0;
      chk_en = 0;
      model_reset();
      repeat (3) @(negedge dclk);
      #1;
      pin("reset", 240, 0, 0);
      check("reset_tick", bus.frame_tick, 0);
      @(negedge dclk);
      clr = 1'b0;
      chk_en = 1;
      repeat (3) @(negedge dclk);

      // Idle frames: nothing moves, one tick per frame.
      t0 = tick_seen;
      repeat (3) run_frame(0, 0, 0, 0);
      check("three_ticks", tick_seen - t0, 3);
      pin("idle", 240, 0, 0);

      // Start and coast upward.
      run_frame(1, 0, 0, 0); pin("start", 240, -8, 1);
      run_frame(0, 0, 0, 0); pin("coast1", 233, -7, 1);
      run_frame(0, 0, 0, 0); pin("coast2", 227, -6, 1);

      // Hit in the tick cycle lands in the following frame.
      run_frame(0, 0, 0, 1); pin("late_hit", 222, -5, 1);
      run_frame(0, 0, 0, 0); pin("late_hit_dead", 218, -4, 2);
      run_frame(1, 0, 0, 0); pin("restart", 240, 0, 0);

      // Glitches never register; a double press yields one impulse.
      run_frame(2, 2, 0, 0);
      run_frame(2, 3, 0, 0);
      run_frame(2, 1, 0, 0);
      pin("glitch", 240, 0, 0);
      run_frame(3, 0, 0, 0); pin("dbl_start", 240, -8, 1);
      run_frame(3, 0, 0, 0); pin("dbl_play", 232, -8, 1);
      run_frame(0, 0, 0, 0); pin("dbl_after", 225, -7, 1);

      // Mid-frame hit kills, then back to a fresh start.
      run_frame(0, 0, 1, 0); pin("hit_dead", 219, -6, 2);
      run_frame(0, 0, 0, 0); pin("dead_frozen", 219, -6, 2);
      run_frame(1, 0, 0, 0); pin("restart2", 240, 0, 0);
      run_frame(1, 0, 0, 0); pin("start2", 240, -8, 1);

      // Flap every frame up to the ceiling.
      repeat (30) run_frame(1, 0, 0, 0);
      pin("at_top", 0, -8, 1);
      run_frame(1, 0, 0, 0); pin("ceiling", 0, 0, 1);

      // Free fall to terminal velocity and the floor.
      run_frame(0, 0, 0, 0); pin("fall1", 1, 1, 1);
      repeat (9) run_frame(0, 0, 0, 0);
      pin("terminal", 55, 10, 1);
      guard = 0;
      while (m_state == 1 && guard < 60) begin
         run_frame(0, 0, 0, 0);
         guard++;
      end
      check("fall_frames", guard, 41);
      pin("floor", 460, 0, 2);
      run_frame(1, 0, 0, 0); pin("restart3", 240, 0, 0);
      run_frame(1, 0, 0, 0); pin("start3", 240, -8, 1);

      // Async clear mid-frame discards a pending flap and hit.
      repeat (5) @(negedge dclk);
      bus.flap_btn = 1'b1;
      repeat (8) @(negedge dclk);
      bus.flap_btn = 1'b0; bus.hit = 1'b1;
      @(negedge dclk);
      bus.hit = 1'b0;
      repeat (3) @(negedge dclk);
      chk_en = 0;
      #5 clr = 1'b1;
      #1;
      pin("clr_mid", 240, 0, 0);
      check("clr_tick", bus.frame_tick, 0);
      model_reset();
      @(negedge dclk);
      clr = 1'b0;
      chk_en = 1;
      run_frame(0, 0, 0, 0);
      run_frame(0, 0, 0, 0);
      pin("post_clr", 240, 0, 0);

      // Random frames against the model.
      t0 = tick_seen;
      frames_run = 0;
      for (int f = 0; f < 150; f++)
         run_frame($urandom_range(0, 3), $urandom_range(1, 3),
                   $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
      check("random_ticks", tick_seen - t0, frames_run);

      chk_en = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
